// File: rtl/crc_gen_chk.sv
// ----------------------------------------------------------------------------
// crc_gen_chk
//   Framed, parametrised CRC generator / checker. Words arrive with sop/eop
//   framing. The eop word carries a count of valid bytes, which are
//   MSB-aligned. Each beat is absorbed in one cycle. One cycle after the eop
//   beat, the result of the frame is presented. In check mode the received
//   frame already contains its own CRC. The final register is then compared
//   with RESIDUE, and every mismatch is counted.
//
// Ports
//   clk_sys, rst_sys      clock, asynchronous active-low reset
//   crc_din               data word, bit DATA_W-1 is first on the wire
//   crc_din_vld           word valid (a "beat")
//   crc_sop / crc_eop     frame delimiters, qualified by crc_din_vld
//   crc_nbytes            valid bytes in the eop word (0 or too big = full)
//   chk_en                check mode, sampled on the sop beat
//   cnt_clr               synchronous clear of err_cnt
//   crc_run               running CRC register (raw, no XOR_OUT)
//   crc_dout              final CRC of last frame (register ^ XOR_OUT)
//   crc_dout_vld          one-cycle pulse: crc_dout / chk_* updated
//   chk_ok                last checked frame matched RESIDUE (held level)
//   chk_err               one-cycle pulse on a checked-frame mismatch
//   proto_err             one-cycle pulse on a framing violation
//   err_cnt               saturating count of chk_err pulses
//   in_frame              frame in progress
// ----------------------------------------------------------------------------
module crc_gen_chk #(
    parameter int                  DATA_W   = 8,
    parameter int                  CRC_W    = 8,
    parameter logic [CRC_W-1:0]    POLY     = 8'h07,
    parameter logic [CRC_W-1:0]    INIT     = {CRC_W{1'b0}},
    parameter logic [CRC_W-1:0]    XOR_OUT  = {CRC_W{1'b0}},
    parameter logic [CRC_W-1:0]    RESIDUE  = {CRC_W{1'b0}},
    parameter int                  ERRCNT_W = 16
) (
    input  logic                          clk_sys,
    input  logic                          rst_sys,
    input  logic [DATA_W-1:0]             crc_din,
    input  logic                          crc_din_vld,
    input  logic                          crc_sop,
    input  logic                          crc_eop,
    input  logic [$clog2(DATA_W/8):0]     crc_nbytes,
    input  logic                          chk_en,
    input  logic                          cnt_clr,
    output logic [CRC_W-1:0]              crc_run,
    output logic [CRC_W-1:0]              crc_dout,
    output logic                          crc_dout_vld,
    output logic                          chk_ok,
    output logic                          chk_err,
    output logic                          proto_err,
    output logic [ERRCNT_W-1:0]           err_cnt,
    output logic                          in_frame
);

    localparam int                NBYTES   = DATA_W / 8;
    localparam int                NB_W     = $clog2(DATA_W / 8) + 1;
    localparam logic [NB_W-1:0]   NBYTES_L = NB_W'(NBYTES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    logic [CRC_W-1:0]      r_crc;
    logic [CRC_W-1:0]      r_crc_dout;
    logic                  r_dout_vld;
    logic                  r_chk_ok;
    logic                  r_chk_err;
    logic                  r_proto_err;
    logic [ERRCNT_W-1:0]   r_err_cnt;
    logic                  r_chk_en;

    logic [NB_W-1:0]       w_nb_eff;
    logic [CRC_W-1:0]      w_base;
    logic [CRC_W-1:0]      w_acc;
    logic [CRC_W-1:0]      w_next;
    logic                  w_chk_en;

    // Eight steps of the bit-serial reference, MSB of the byte first.
    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                  input logic [7:0]       b);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ b[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
        end
        return r;
    endfunction

    // Effective byte count: only the eop word may be partial, and out-of-range counts mean a full word.
    always_comb begin
        w_nb_eff = NBYTES_L;
        if (crc_eop && (crc_nbytes != {NB_W{1'b0}}) && (crc_nbytes <= NBYTES_L)) begin
            w_nb_eff = crc_nbytes;
        end else begin
            w_nb_eff = NBYTES_L;
        end
    end

    // A sop beat always restarts from INIT, including one that aborts a frame.
    always_comb begin
        w_base   = crc_sop ? INIT : r_crc;
        w_chk_en = crc_sop ? chk_en : r_chk_en;
    end

    // Byte chain over the word. The tap after k bytes is selected when k bytes are valid.
    always_comb begin
        w_acc  = w_base;
        w_next = w_base;
        for (int k = 1; k <= NBYTES; k++) begin
            w_acc  = crc_byte(w_acc, crc_din[DATA_W-8*k +: 8]);
            w_next = (NB_W'(k) == w_nb_eff) ? w_acc : w_next;
        end
    end

    // Framing FSM, CRC register, result/check outputs and error counter.
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            r_state     <= ST_IDLE;
            r_crc       <= INIT;
            r_crc_dout  <= {CRC_W{1'b0}};
            r_dout_vld  <= 1'b0;
            r_chk_ok    <= 1'b0;
            r_chk_err   <= 1'b0;
            r_proto_err <= 1'b0;
            r_err_cnt   <= {ERRCNT_W{1'b0}};
            r_chk_en    <= 1'b0;
        end else begin
            r_dout_vld  <= 1'b0;
            r_chk_err   <= 1'b0;
            r_proto_err <= 1'b0;

            // The counter counts the registered chk_err pulse, so a clear in that same cycle wins.
            if (cnt_clr) begin
                r_err_cnt <= {ERRCNT_W{1'b0}};
            end else if (r_chk_err && (r_err_cnt != {ERRCNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
            end else begin
                r_err_cnt <= r_err_cnt;
            end

            if (crc_din_vld) begin
                if (crc_sop || (r_state == ST_BUSY)) begin
                    r_crc <= w_next;
                    if (crc_sop) begin
                        r_chk_en    <= chk_en;
                        r_proto_err <= (r_state == ST_BUSY);
                    end else begin
                        r_chk_en    <= r_chk_en;
                    end
                    if (crc_eop) begin
                        r_state    <= ST_IDLE;
                        r_crc_dout <= w_next ^ XOR_OUT;
                        r_dout_vld <= 1'b1;
                        if (w_chk_en) begin
                            r_chk_ok  <= (w_next == RESIDUE);
                            r_chk_err <= (w_next != RESIDUE);
                        end else begin
                            r_chk_ok  <= r_chk_ok;
                        end
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end else begin
                    // Data outside a frame is dropped.
                    r_proto_err <= 1'b1;
                end
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign crc_run      = r_crc;
    assign crc_dout     = r_crc_dout;
    assign crc_dout_vld = r_dout_vld;
    assign chk_ok       = r_chk_ok;
    assign chk_err      = r_chk_err;
    assign proto_err    = r_proto_err;
    assign err_cnt      = r_err_cnt;
    assign in_frame     = (r_state == ST_BUSY);

endmodule

// File: tb/tb_crc_gen_chk.sv
// ----------------------------------------------------------------------------
// tb_crc_gen_chk
//   Directed bench for crc_gen_chk. Two instances share the clock and reset:
//     A: 8-bit data, CRC-8 poly 07, INIT 0, 2-bit error counter
//     B: 16-bit data, CRC-16 poly 1021, INIT FFFF
//   Expected values are constants computed by hand from the bit-serial CRC
//   definition.
// ----------------------------------------------------------------------------
module tb_crc_gen_chk;

    logic clk_sys = 1'b0;
    logic rst_sys = 1'b0;

    always #5 clk_sys = ~clk_sys;

    // Instance A (CRC-8)
    logic [7:0]  a_din;
    logic        a_vld, a_sop, a_eop, a_chk, a_clr;
    logic [0:0]  a_nb;
    logic [7:0]  a_run, a_dout;
    logic        a_dvld, a_ok, a_err, a_perr, a_inf;
    logic [1:0]  a_cnt;

    // Instance B (CRC-16)
    logic [15:0] b_din;
    logic        b_vld, b_sop, b_eop, b_chk, b_clr;
    logic [1:0]  b_nb;
    logic [15:0] b_run, b_dout;
    logic        b_dvld, b_ok, b_err, b_perr, b_inf;
    logic [15:0] b_cnt;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]  msg [0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                               8'h36, 8'h37, 8'h38, 8'h39};
    logic [15:0] w16 [0:4] = '{16'h3132, 16'h3334, 16'h3536, 16'h3738, 16'h39A5};

    crc_gen_chk #(
        .DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00),
        .XOR_OUT(8'h00), .RESIDUE(8'h00), .ERRCNT_W(2)
    ) u_a (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .crc_din(a_din), .crc_din_vld(a_vld), .crc_sop(a_sop), .crc_eop(a_eop),
        .crc_nbytes(a_nb), .chk_en(a_chk), .cnt_clr(a_clr),
        .crc_run(a_run), .crc_dout(a_dout), .crc_dout_vld(a_dvld),
        .chk_ok(a_ok), .chk_err(a_err), .proto_err(a_perr),
        .err_cnt(a_cnt), .in_frame(a_inf)
    );

    crc_gen_chk #(
        .DATA_W(16), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF),
        .XOR_OUT(16'h0000), .RESIDUE(16'h0000), .ERRCNT_W(16)
    ) u_b (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .crc_din(b_din), .crc_din_vld(b_vld), .crc_sop(b_sop), .crc_eop(b_eop),
        .crc_nbytes(b_nb), .chk_en(b_chk), .cnt_clr(b_clr),
        .crc_run(b_run), .crc_dout(b_dout), .crc_dout_vld(b_dvld),
        .chk_ok(b_ok), .chk_err(b_err), .proto_err(b_perr),
        .err_cnt(b_cnt), .in_frame(b_inf)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One beat on A; outputs reflecting this beat are sampled on return.
    task automatic beat_a(input logic [7:0] d, input logic s, input logic e, input logic c);
        a_din = d; a_sop = s; a_eop = e; a_chk = c; a_vld = 1'b1;
        tick();
        a_vld = 1'b0; a_sop = 1'b0; a_eop = 1'b0;
    endtask

    task automatic beat_b(input logic [15:0] d, input logic s, input logic e, input logic [1:0] nb);
        b_din = d; b_sop = s; b_eop = e; b_nb = nb; b_vld = 1'b1;
        tick();
        b_vld = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
    endtask

    // "123456789" on A, optionally followed by one appended CRC byte.
    task automatic frame_a(input logic c, input logic with_crc, input logic [7:0] crc_b);
        for (int i = 0; i < 9; i++) begin
            beat_a(msg[i], (i == 0), (i == 8) && !with_crc, c);
        end
        if (with_crc) begin
            beat_a(crc_b, 1'b0, 1'b1, c);
        end
    endtask

    task automatic test_reset();
        a_din = 8'h00; a_vld = 1'b0; a_sop = 1'b0; a_eop = 1'b0; a_chk = 1'b0; a_clr = 1'b0; a_nb = 1'b0;
        b_din = 16'h0000; b_vld = 1'b0; b_sop = 1'b0; b_eop = 1'b0; b_chk = 1'b0; b_clr = 1'b0; b_nb = 2'd0;
        rst_sys = 1'b0;
        #12;
        vectors++; if (a_run !== 8'h00) begin miscompares++; $display("FAIL reset_a_run: got %h want %h", a_run, 8'h00); end
        vectors++; if (b_run !== 16'hFFFF) begin miscompares++; $display("FAIL reset_b_run: got %h want %h", b_run, 16'hFFFF); end
        vectors++; if ({a_dout, a_dvld, a_ok, a_err, a_perr, a_cnt, a_inf} !== 15'd0) begin
            miscompares++; $display("FAIL reset_a_outs: dout %h vld %b ok %b err %b perr %b cnt %h inf %b, want all 0",
                                    a_dout, a_dvld, a_ok, a_err, a_perr, a_cnt, a_inf);
        end
        @(negedge clk_sys);
        rst_sys = 1'b1;
        tick();
    endtask

    task automatic test_crc8_basic();
        beat_a(msg[0], 1'b1, 1'b0, 1'b0);
        vectors++; if (a_run !== 8'h97) begin miscompares++; $display("FAIL crc8_run_first: got %h want %h", a_run, 8'h97); end
        vectors++; if (a_inf !== 1'b1) begin miscompares++; $display("FAIL crc8_in_frame: got %b want 1", a_inf); end
        for (int i = 1; i < 9; i++) begin
            vectors++; if (a_dvld !== 1'b0) begin miscompares++; $display("FAIL crc8_early_vld: got %b want 0", a_dvld); end
            beat_a(msg[i], 1'b0, (i == 8), 1'b0);
        end
        vectors++; if (a_dout !== 8'hF4) begin miscompares++; $display("FAIL crc8_dout: got %h want %h", a_dout, 8'hF4); end
        vectors++; if (a_dvld !== 1'b1) begin miscompares++; $display("FAIL crc8_dvld: got %b want 1", a_dvld); end
        vectors++; if (a_inf !== 1'b0) begin miscompares++; $display("FAIL crc8_in_frame_end: got %b want 0", a_inf); end
        tick();
        vectors++; if (a_dvld !== 1'b0) begin miscompares++; $display("FAIL crc8_dvld_pulse: got %b want 0", a_dvld); end
        // single-word frame
        beat_a(8'h31, 1'b1, 1'b1, 1'b0);
        vectors++; if (a_dout !== 8'h97 || a_dvld !== 1'b1 || a_inf !== 1'b0) begin
            miscompares++; $display("FAIL crc8_single: dout %h vld %b inf %b want 97 1 0", a_dout, a_dvld, a_inf);
        end
        tick();
    endtask

    task automatic test_crc16_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 5; i++) begin
                // second frame carries junk nbytes on non-eop words, which must be ignored
                beat_b(w16[i], (i == 0), (i == 4), (i == 4) ? 2'd1 : ((f == 1) ? 2'd1 : 2'd2));
                if (i == 0 && f == 1) begin
                    vectors++; if (b_dvld !== 1'b0 || b_perr !== 1'b0 || b_inf !== 1'b1) begin
                        miscompares++; $display("FAIL crc16_b2b_sop: dvld %b perr %b inf %b want 0 0 1", b_dvld, b_perr, b_inf);
                    end
                end
            end
            vectors++; if (b_dout !== 16'h29B1 || b_dvld !== 1'b1) begin
                miscompares++; $display("FAIL crc16_frame%0d: dout %h vld %b want 29b1 1", f, b_dout, b_dvld);
            end
        end
        tick();
        vectors++; if (b_inf !== 1'b0 || b_dvld !== 1'b0) begin
            miscompares++; $display("FAIL crc16_idle: inf %b dvld %b want 0 0", b_inf, b_dvld);
        end
    endtask

    task automatic test_check();
        frame_a(1'b1, 1'b1, 8'hF4);
        vectors++; if (a_ok !== 1'b1 || a_err !== 1'b0 || a_dout !== 8'h00 || a_dvld !== 1'b1) begin
            miscompares++; $display("FAIL chk_good: ok %b err %b dout %h vld %b want 1 0 00 1", a_ok, a_err, a_dout, a_dvld);
        end
        tick();
        vectors++; if (a_cnt !== 2'd0) begin miscompares++; $display("FAIL chk_good_cnt: got %0d want 0", a_cnt); end
        frame_a(1'b1, 1'b1, 8'hF5);
        vectors++; if (a_ok !== 1'b0 || a_err !== 1'b1 || a_dout !== 8'h07) begin
            miscompares++; $display("FAIL chk_bad: ok %b err %b dout %h want 0 1 07", a_ok, a_err, a_dout);
        end
        tick();
        vectors++; if (a_cnt !== 2'd1 || a_err !== 1'b0) begin
            miscompares++; $display("FAIL chk_bad_cnt: cnt %0d err %b want 1 0", a_cnt, a_err);
        end
    endtask

    task automatic test_saturate();
        for (int n = 2; n <= 4; n++) begin
            frame_a(1'b1, 1'b1, 8'hF5);
            tick();
            vectors++; if (a_cnt !== ((n > 3) ? 2'd3 : 2'(n))) begin
                miscompares++; $display("FAIL sat_cnt_%0d: got %0d want %0d", n, a_cnt, (n > 3) ? 3 : n);
            end
        end
    endtask

    task automatic test_cnt_clr();
        frame_a(1'b1, 1'b1, 8'hF5);
        vectors++; if (a_err !== 1'b1) begin miscompares++; $display("FAIL clr_err_pulse: got %b want 1", a_err); end
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        vectors++; if (a_cnt !== 2'd0) begin miscompares++; $display("FAIL clr_cnt: got %0d want 0", a_cnt); end
        // good checked frame sets chk_ok; an unchecked frame leaves it alone
        frame_a(1'b1, 1'b1, 8'hF4);
        frame_a(1'b0, 1'b1, 8'hF5);
        vectors++; if (a_ok !== 1'b1 || a_err !== 1'b0 || a_dout !== 8'h07) begin
            miscompares++; $display("FAIL nochk_hold: ok %b err %b dout %h want 1 0 07", a_ok, a_err, a_dout);
        end
        tick();
        vectors++; if (a_cnt !== 2'd0) begin miscompares++; $display("FAIL nochk_cnt: got %0d want 0", a_cnt); end
    endtask

    task automatic test_proto();
        beat_a(8'hAA, 1'b0, 1'b0, 1'b0);
        vectors++; if (a_perr !== 1'b1 || a_run !== 8'h07 || a_inf !== 1'b0 || a_dvld !== 1'b0) begin
            miscompares++; $display("FAIL proto_idle: perr %b run %h inf %b dvld %b want 1 07 0 0", a_perr, a_run, a_inf, a_dvld);
        end
        // vld low: nothing changes even with sop/eop asserted
        a_din = 8'h31; a_sop = 1'b1; a_eop = 1'b1;
        tick();
        a_sop = 1'b0; a_eop = 1'b0;
        vectors++; if (a_perr !== 1'b0 || a_run !== 8'h07 || a_inf !== 1'b0 || a_dvld !== 1'b0) begin
            miscompares++; $display("FAIL vld_low: perr %b run %h inf %b dvld %b want 0 07 0 0", a_perr, a_run, a_inf, a_dvld);
        end
        // sop mid-frame aborts the first frame
        beat_a(8'h31, 1'b1, 1'b0, 1'b0);
        beat_a(8'h32, 1'b0, 1'b0, 1'b0);
        beat_a(8'h33, 1'b0, 1'b0, 1'b0);
        beat_a(msg[0], 1'b1, 1'b0, 1'b0);
        vectors++; if (a_perr !== 1'b1 || a_dvld !== 1'b0 || a_inf !== 1'b1 || a_run !== 8'h97) begin
            miscompares++; $display("FAIL proto_abort: perr %b dvld %b inf %b run %h want 1 0 1 97", a_perr, a_dvld, a_inf, a_run);
        end
        for (int i = 1; i < 9; i++) begin
            beat_a(msg[i], 1'b0, (i == 8), 1'b0);
        end
        vectors++; if (a_dout !== 8'hF4 || a_dvld !== 1'b1) begin
            miscompares++; $display("FAIL proto_restart: dout %h vld %b want f4 1", a_dout, a_dvld);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 4; i++) begin
            beat_a(msg[i], (i == 0), 1'b0, 1'b0);
        end
        #2;
        rst_sys = 1'b0;
        #1;
        vectors++; if (a_run !== 8'h00 || a_inf !== 1'b0 || a_dout !== 8'h00 || a_ok !== 1'b0 || a_cnt !== 2'd0 || a_dvld !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid: run %h inf %b dout %h ok %b cnt %0d dvld %b want 00 0 00 0 0 0",
                                    a_run, a_inf, a_dout, a_ok, a_cnt, a_dvld);
        end
        vectors++; if (b_run !== 16'hFFFF || b_dout !== 16'h0000) begin
            miscompares++; $display("FAIL reset_mid_b: run %h dout %h want ffff 0000", b_run, b_dout);
        end
        @(negedge clk_sys);
        rst_sys = 1'b1;
        tick();
        frame_a(1'b0, 1'b0, 8'h00);
        vectors++; if (a_dout !== 8'hF4 || a_dvld !== 1'b1) begin
            miscompares++; $display("FAIL reset_recover: dout %h vld %b want f4 1", a_dout, a_dvld);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_crc8_basic();
        test_crc16_back_to_back();
        test_check();
        test_saturate();
        test_cnt_clr();
        test_proto();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
